// File: rtl/id_stage_front.sv
// id_stage_front: ID-stage pipeline latch with early branch resolution.
// Accepts {pc, inst} from IF, reads rj/rkd through async register-file ports,
// resolves B/BL/BEQ/BNE, kills the wrong-path IF bundle on a taken branch and
// hands {pc, inst, rj_value, rkd_value} to EX.
// Optional: define BR_EXT_EN to also resolve BLT/BGE/BLTU/BGEU and JIRL.
module id_stage_front #(
  parameter int to_ID_data_width = 64,
  parameter int to_EX_data_width = 128
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        IF_to_ID_valid,
  input  logic [to_ID_data_width-1:0] to_ID_data,
  output logic                        ID_allow_in,
  input  logic                        ID_stall,
  input  logic                        EX_allow_in,
  output logic                        ID_to_EX_valid,
  output logic [to_EX_data_width-1:0] to_EX_data,
  output logic [4:0]                  rf_raddr1,
  input  logic [31:0]                 rf_rdata1,
  output logic [4:0]                  rf_raddr2,
  input  logic [31:0]                 rf_rdata2,
  output logic                        br_taken,
  output logic [31:0]                 br_target
);

  localparam logic [5:0] OP_B    = 6'b010100;
  localparam logic [5:0] OP_BL   = 6'b010101;
  localparam logic [5:0] OP_BEQ  = 6'b010110;
  localparam logic [5:0] OP_BNE  = 6'b010111;
`ifdef BR_EXT_EN
  localparam logic [5:0] OP_BLT  = 6'b011000;
  localparam logic [5:0] OP_BGE  = 6'b011001;
  localparam logic [5:0] OP_BLTU = 6'b011010;
  localparam logic [5:0] OP_BGEU = 6'b011011;
  localparam logic [5:0] OP_JIRL = 6'b010011;
`endif

  logic                        id_valid_q, id_valid_d;
  logic [to_ID_data_width-1:0] id_data_q, id_data_d;

  logic [31:0] pc;
  logic [31:0] inst;
  logic [5:0]  op;
  logic [31:0] offs26;
  logic [31:0] offs16;
  logic        id_ready_go;
  logic        fire;
  logic        use_rd;
  logic        br_cond;
  logic [31:0] br_tgt;
  logic        eq;

  assign pc     = id_data_q[63:32];
  assign inst   = id_data_q[31:0];
  assign op     = inst[31:26];
  assign offs26 = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
  assign offs16 = {{14{inst[25]}}, inst[25:10], 2'b00};
  assign eq     = (rf_rdata1 == rf_rdata2);

  assign id_ready_go    = ~ID_stall;
  assign ID_allow_in    = ~id_valid_q | (id_ready_go & EX_allow_in);
  assign ID_to_EX_valid = id_valid_q & id_ready_go;
  assign fire           = ID_to_EX_valid & EX_allow_in;

  assign rf_raddr1  = inst[9:5];
  assign rf_raddr2  = use_rd ? inst[4:0] : inst[14:10];
  assign to_EX_data = {pc, inst, rf_rdata1, rf_rdata2};

  assign br_taken  = fire & br_cond;
  assign br_target = br_taken ? br_tgt : 32'd0;

  // Branch opcodes compare rj against rd, so the second read port switches to rd.
  always_comb begin
    use_rd = 1'b0;
    case (op)
      OP_B, OP_BL, OP_BEQ, OP_BNE: use_rd = 1'b1;
`ifdef BR_EXT_EN
      OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JIRL: use_rd = 1'b1;
`endif
      default: use_rd = 1'b0;
    endcase
  end

  // Resolve branch condition and redirect target from the held instruction.
  always_comb begin
    br_cond = 1'b0;
    br_tgt  = pc + offs16;
    case (op)
      OP_B, OP_BL: begin
        br_cond = 1'b1;
        br_tgt  = pc + offs26;
      end
      OP_BEQ: br_cond = eq;
      OP_BNE: br_cond = ~eq;
`ifdef BR_EXT_EN
      OP_BLT:  br_cond = ($signed(rf_rdata1) < $signed(rf_rdata2));
      OP_BGE:  br_cond = ($signed(rf_rdata1) >= $signed(rf_rdata2));
      OP_BLTU: br_cond = (rf_rdata1 < rf_rdata2);
      OP_BGEU: br_cond = (rf_rdata1 >= rf_rdata2);
      OP_JIRL: begin
        br_cond = 1'b1;
        br_tgt  = rf_rdata1 + offs16;
      end
`endif
      default: br_cond = 1'b0;
    endcase
  end

  // Next-state for the pipeline latch; a taken branch drops the wrong-path IF bundle.
  always_comb begin
    id_valid_d = id_valid_q;
    id_data_d  = id_data_q;
    if (ID_allow_in) begin
      id_valid_d = IF_to_ID_valid & ~br_taken;
    end
    if (IF_to_ID_valid & ID_allow_in) begin
      id_data_d = to_ID_data;
    end
  end

  // Pipeline latch registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid_q <= 1'b0;
      id_data_q  <= '0;
    end else begin
      id_valid_q <= id_valid_d;
      id_data_q  <= id_data_d;
    end
  end

endmodule

// File: tb/tb_id_stage_front.sv
// Bench for id_stage_front: scoreboard of expected EX hand-offs plus directed checks.
module tb_id_stage_front;

  logic         clk;
  logic         reset;
  logic         IF_to_ID_valid;
  logic [63:0]  to_ID_data;
  logic         ID_allow_in;
  logic         ID_stall;
  logic         EX_allow_in;
  logic         ID_to_EX_valid;
  logic [127:0] to_EX_data;
  logic [4:0]   rf_raddr1;
  logic [31:0]  rf_rdata1;
  logic [4:0]   rf_raddr2;
  logic [31:0]  rf_rdata2;
  logic         br_taken;
  logic [31:0]  br_target;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb[$];

  localparam logic [31:0] I_ADD  = 32'h00100c41;
  localparam logic [31:0] I_B4   = 32'h50000400;
  localparam logic [31:0] I_BEQ  = 32'h5bfffc22;
  localparam logic [31:0] I_BNE  = 32'h5c000822;
  localparam logic [31:0] I_BLT  = 32'h60001022;
  localparam logic [31:0] I_BLTU = 32'h68001022;
  localparam logic [31:0] I_JIRL = 32'h4c000423;

  id_stage_front dut (
    .clk            (clk),
    .reset          (reset),
    .IF_to_ID_valid (IF_to_ID_valid),
    .to_ID_data     (to_ID_data),
    .ID_allow_in    (ID_allow_in),
    .ID_stall       (ID_stall),
    .EX_allow_in    (EX_allow_in),
    .ID_to_EX_valid (ID_to_EX_valid),
    .to_EX_data     (to_EX_data),
    .rf_raddr1      (rf_raddr1),
    .rf_rdata1      (rf_rdata1),
    .rf_raddr2      (rf_raddr2),
    .rf_rdata2      (rf_rdata2),
    .br_taken       (br_taken),
    .br_target      (br_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model of branch resolution: {taken, target}.
  function automatic logic [32:0] model(input logic [31:0] pc, input logic [31:0] inst,
                                        input logic [31:0] r1, input logic [31:0] r2);
    logic [31:0] o26, o16;
    o26 = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
    o16 = {{14{inst[25]}}, inst[25:10], 2'b00};
    case (inst[31:26])
      6'h14, 6'h15: return {1'b1, pc + o26};
      6'h16: return (r1 == r2) ? {1'b1, pc + o16} : 33'd0;
      6'h17: return (r1 != r2) ? {1'b1, pc + o16} : 33'd0;
`ifdef BR_EXT_EN
      6'h18: return ($signed(r1) <  $signed(r2)) ? {1'b1, pc + o16} : 33'd0;
      6'h19: return ($signed(r1) >= $signed(r2)) ? {1'b1, pc + o16} : 33'd0;
      6'h1a: return (r1 <  r2) ? {1'b1, pc + o16} : 33'd0;
      6'h1b: return (r1 >= r2) ? {1'b1, pc + o16} : 33'd0;
      6'h13: return {1'b1, r1 + o16};
`endif
      default: return 33'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one bundle; it is accepted at the next edge, then rf data for it is driven.
  task automatic offer(input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] r1, input logic [31:0] r2, input bit push);
    exp_t e;
    logic [32:0] m;
    IF_to_ID_valid = 1'b1;
    to_ID_data     = {pc, inst};
    if (push) begin
      m = model(pc, inst, r1, r2);
      e.pc = pc; e.inst = inst; e.taken = m[32]; e.tgt = m[31:0];
      sb.push_back(e);
    end
    tick();
    IF_to_ID_valid = 1'b0;
    rf_rdata1      = r1;
    rf_rdata2      = r2;
    #1;
  endtask

  // Scoreboard: every EX hand-off must match the next expected bundle.
  always @(negedge clk) begin
    if (!reset && ID_to_EX_valid && EX_allow_in) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_fire", 128'd1, 128'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("sb_pc",     128'(to_EX_data[127:96]), 128'(e.pc));
        check_eq("sb_inst",   128'(to_EX_data[95:64]),  128'(e.inst));
        check_eq("sb_taken",  128'(br_taken),           128'(e.taken));
        check_eq("sb_target", 128'(br_target),          128'(e.tgt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; IF_to_ID_valid = 1'b0; to_ID_data = '0; ID_stall = 1'b0;
    EX_allow_in = 1'b1; rf_rdata1 = '0; rf_rdata2 = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check_eq("rst_valid",   128'(ID_to_EX_valid), 128'd0);
    check_eq("rst_taken",   128'(br_taken),       128'd0);
    check_eq("rst_data",    to_EX_data,           128'd0);
    check_eq("rst_allow",   128'(ID_allow_in),    128'd1);

    // Plain ADD.W passes through in one cycle.
    offer(32'h1c000000, I_ADD, 32'd0, 32'd0, 1'b1);
    check_eq("add_valid",  128'(ID_to_EX_valid),     128'd1);
    check_eq("add_pc",     128'(to_EX_data[127:96]), 128'h1c000000);
    check_eq("add_taken",  128'(br_taken),           128'd0);
    check_eq("add_raddr1", 128'(rf_raddr1),          128'd2);
    check_eq("add_raddr2", 128'(rf_raddr2),          128'd3);
    tick();

    // B +4 taken; the sequential bundle offered in the same cycle is dropped.
    offer(32'h1c000008, I_B4, 32'd0, 32'd0, 1'b1);
    IF_to_ID_valid = 1'b1;
    to_ID_data     = {32'h1c00000c, I_ADD};
    #1;
    check_eq("b_taken",  128'(br_taken),    128'd1);
    check_eq("b_target", 128'(br_target),   128'h1c00000c);
    tick();
    IF_to_ID_valid = 1'b0;
    #1;
    check_eq("b_kill",   128'(ID_to_EX_valid), 128'd0);
    check_eq("b_nopulse", 128'(br_taken),      128'd0);

    // BEQ equal: taken backwards.
    offer(32'h1c000010, I_BEQ, 32'd5, 32'd5, 1'b1);
    check_eq("beq_raddr1", 128'(rf_raddr1), 128'd1);
    check_eq("beq_raddr2", 128'(rf_raddr2), 128'd2);
    check_eq("beq_taken",  128'(br_taken),  128'd1);
    check_eq("beq_target", 128'(br_target), 128'h1c00000c);
    tick();

    // BEQ unequal: not taken, next instruction retained.
    offer(32'h1c000010, I_BEQ, 32'd5, 32'd6, 1'b1);
    check_eq("beqn_taken",  128'(br_taken),  128'd0);
    check_eq("beqn_target", 128'(br_target), 128'd0);
    IF_to_ID_valid = 1'b1;
    to_ID_data     = {32'h1c000014, I_ADD};
    sb.push_back('{pc: 32'h1c000014, inst: I_ADD, taken: 1'b0, tgt: 32'd0});
    tick();
    IF_to_ID_valid = 1'b0;
    #1;
    check_eq("beqn_next_valid", 128'(ID_to_EX_valid),     128'd1);
    check_eq("beqn_next_pc",    128'(to_EX_data[127:96]), 128'h1c000014);
    tick();

    // BNE held by stall for 3 cycles, then a single taken pulse.
    ID_stall = 1'b1;
    offer(32'h1c000020, I_BNE, 32'd3, 32'd4, 1'b1);
    IF_to_ID_valid = 1'b1;
    to_ID_data     = {32'h1c000024, I_ADD};
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("stall_taken", 128'(br_taken),    128'd0);
      check_eq("stall_allow", 128'(ID_allow_in), 128'd0);
      check_eq("stall_data",  to_EX_data, {32'h1c000020, I_BNE, 32'd3, 32'd4});
      tick();
    end
    ID_stall = 1'b0;
    IF_to_ID_valid = 1'b0;
    #1;
    check_eq("bne_taken",  128'(br_taken),  128'd1);
    check_eq("bne_target", 128'(br_target), 128'h1c000028);
    tick();
    check_eq("bne_single", 128'(br_taken),       128'd0);
    check_eq("bne_empty",  128'(ID_to_EX_valid), 128'd0);

    // EX back-pressure holds ID; reset mid-hold empties it.
    offer(32'h1c000030, I_ADD, 32'd0, 32'd0, 1'b0);
    EX_allow_in    = 1'b0;
    IF_to_ID_valid = 1'b1;
    to_ID_data     = {32'h1c000034, 32'h00100c42};
    #1;
    check_eq("exh_allow", 128'(ID_allow_in), 128'd0);
    tick();
    check_eq("exh_data", 128'(to_EX_data[127:64]), {32'h1c000030, I_ADD});
    check_eq("exh_valid", 128'(ID_to_EX_valid),    128'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0; IF_to_ID_valid = 1'b0; EX_allow_in = 1'b1;
    #1;
    check_eq("rsth_valid", 128'(ID_to_EX_valid), 128'd0);
    check_eq("rsth_taken", 128'(br_taken),       128'd0);

    // Reset while a taken branch is resident.
    offer(32'h1c000040, I_B4, 32'd0, 32'd0, 1'b0);
    reset = 1'b1;
    IF_to_ID_valid = 1'b1;
    to_ID_data     = {32'h1c000044, I_ADD};
    tick();
    reset = 1'b0; IF_to_ID_valid = 1'b0;
    #1;
    check_eq("rstb_valid", 128'(ID_to_EX_valid), 128'd0);
    check_eq("rstb_taken", 128'(br_taken),       128'd0);

    // Extended branch opcodes.
    offer(32'h1c000050, I_BLT, 32'hffffffff, 32'd1, 1'b1);
`ifdef BR_EXT_EN
    check_eq("blt_taken",  128'(br_taken),  128'd1);
    check_eq("blt_target", 128'(br_target), 128'h1c000060);
    check_eq("blt_raddr2", 128'(rf_raddr2), 128'd2);
`else
    check_eq("blt_taken",  128'(br_taken),  128'd0);
    check_eq("blt_raddr2", 128'(rf_raddr2), 128'd4);
`endif
    tick();
    offer(32'h1c000050, I_BLTU, 32'hffffffff, 32'd1, 1'b1);
    check_eq("bltu_taken", 128'(br_taken), 128'd0);
    tick();
    offer(32'h1c000060, I_JIRL, 32'h1c001000, 32'd0, 1'b1);
`ifdef BR_EXT_EN
    check_eq("jirl_taken",  128'(br_taken),  128'd1);
    check_eq("jirl_target", 128'(br_target), 128'h1c001004);
`else
    check_eq("jirl_taken",  128'(br_taken),  128'd0);
`endif
    tick();
    tick();

    check_eq("sb_drained", 128'(sb.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage_front.md
Name: id_stage_front

Overview:
- Receiving end of the IF→ID pipeline handshake: the ID-stage pipeline latch plus early branch resolution for the LoongArch pipelined CPU.
- Accepts {pc, inst} from the fetch stage and holds it under downstream stall.
- Reads rj/rkd via async register-file ports, resolves B/BL/BEQ/BNE in ID, and forwards {pc, inst, operands} to EX.
- On a taken branch it kills the wrong-path instruction sitting in IF and drives the redirect target back toward the pre-IF nextpc mux.

Parameters:
- to_ID_data_width, 64, IF→ID bundle width {pc[63:32], inst[31:0]}
- to_EX_data_width, 128, ID→EX bundle width {pc, inst, rj_value, rkd_value}

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- IF_to_ID_valid  input  1  fetch bundle valid
- to_ID_data  input  to_ID_data_width  {pc, inst}
- ID_allow_in  output  1  ID can accept a bundle this cycle
- ID_stall  input  1  external hazard stall; holds ID
- EX_allow_in  input  1  EX can accept
- ID_to_EX_valid  output  1  bundle to EX valid
- to_EX_data  output  to_EX_data_width  {pc, inst, rj_value, rkd_value}
- rf_raddr1  output  5  inst[9:5] (rj)
- rf_rdata1  input  32  async read data for raddr1
- rf_raddr2  output  5  inst[4:0] (rd) for branch opcodes, else inst[14:10] (rk)
- rf_rdata2  input  32  async read data for raddr2
- br_taken  output  1  redirect pulse
- br_target  output  32  redirect address

Behaviour:
- State: ID_valid (1b), ID_data (to_ID_data_width). Reset: both 0, so ID_to_EX_valid=0, br_taken=0, to_EX_data=0 after reset.
- ID_ready_go = ~ID_stall.
- ID_allow_in = ~ID_valid | (ID_ready_go & EX_allow_in).
- ID_to_EX_valid = ID_valid & ID_ready_go.
- fire = ID_to_EX_valid & EX_allow_in.
- Latch: if ID_allow_in, ID_valid <= IF_to_ID_valid & ~br_taken; ID_data <= to_ID_data whenever IF_to_ID_valid & ID_allow_in. Otherwise hold. Latency IF→EX is 1 cycle when unstalled.
- Decode on ID_data: pc=[63:32], inst=[31:0], op=inst[31:26].
  - B=010100, BL=010101: target = pc + sext({inst[9:0], inst[25:10], 2'b00}).
  - BEQ=010110, BNE=010111: target = pc + sext({inst[25:10], 2'b00}); compare rf_rdata1 vs rf_rdata2.
  - All adds are 32-bit modulo (wrap-around allowed, no flag).
- br_taken = fire & (B | BL | (BEQ & eq) | (BNE & ~eq)): a one-cycle pulse, asserted only on fire, never while stalled. br_target equals the computed target when br_taken, else 0.
- Kill rule: at the edge where br_taken=1, ID_valid <= 0 regardless of IF_to_ID_valid. This drops the sequential instruction from IF. The next bundle accepted is the fetch from br_target.
- Stall: ID_stall=1 with ID_valid holds ID_data/ID_valid; ID_allow_in=0 stalls IF. Branch resolution is deferred until fire.
- ID_stall=1 with ID empty: ID_allow_in=1, so a bundle is still accepted.
- EX_allow_in=0: same hold behaviour as stall.
- to_EX_data = {pc, inst, rf_rdata1, rf_rdata2}, combinational from current ID_data.
- Reset mid-stall or mid-branch: next cycle ID empty, no br_taken.
- Non-branch opcodes: pass through, br_taken=0.

Optional Feature:
- BR_EXT_EN: defined → additionally resolve BLT=011000 (signed <), BGE=011001 (signed >=), BLTU=011010, BGEU=011011, all pc-relative offs16.
- Also JIRL=010011: target = rf_rdata1 + sext({inst[25:10], 2'b00}), always taken. rf_raddr2 uses rd for these opcodes.
- Undefined → these opcodes are non-branch (br_taken=0, raddr2=inst[14:10]).

Test Plan:
- Reset; then IF_to_ID_valid=1, to_ID_data={0x1c000000, 0x00100c41 (ADD.W)}, EX_allow_in=1 → next cycle ID_to_EX_valid=1, to_EX_data[127:96]=0x1c000000, br_taken=0.
- ID holds B, offs26=+4 (inst 0x50000400) at pc=0x1c000008, fire → br_taken=1, br_target=0x1c00000c. Bundle pc=0x1c00000c offered that cycle is dropped (ID_valid=0 next cycle).
- BEQ rj=1, rd=2 at pc=0x1c000010, offs16=-1 (inst 0x5bfffc22), rf_rdata1=rf_rdata2=5 → br_target=0x1c00000c. With rf_rdata2=6 → br_taken=0, next instruction retained.
- BNE held with ID_stall=1 for 3 cycles → br_taken=0, ID_allow_in=0, to_EX_data stable. Release → single br_taken pulse.
- EX_allow_in=0 with ID full and a new IF bundle offered → bundle not accepted, ID_data unchanged. Reset asserted mid-hold → ID_to_EX_valid=0 next cycle.
- BR_EXT_EN: BLT with rf_rdata1=0xffffffff, rf_rdata2=1 → taken. BLTU same operands → not taken. JIRL rj=0x1c001000, offs16=1 → br_target=0x1c001004.
